// File: rtl/header_feeder_pkg.sv
// Shared constants, FSM state type and byte-to-word helpers for header_feeder.
package hdr_feeder_pkg;

  localparam int HDR_BYTES  = 80;
  localparam int HDR_WORDS  = 20;
  localparam int NONCE_WORD = 19;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  // Header byte n lives in word n/4.
  function automatic logic [4:0] byte_word(input logic [6:0] idx);
    return idx[6:2];
  endfunction

  // Big-endian lane: byte 0 of a word occupies bits [31:24].
  function automatic int byte_lane_lsb(input logic [6:0] idx);
    int lsb;
    case (idx[1:0])
      2'd0:    lsb = 24;
      2'd1:    lsb = 16;
      2'd2:    lsb = 8;
      default: lsb = 0;
    endcase
    return lsb;
  endfunction

endpackage

// File: rtl/header_feeder_if.sv
// Word request bus between sha256d_wrapper (master) and header_feeder (slave).
interface header_feeder_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] addr;
  logic              rq;
  logic [31:0]       data;
  logic              rdy;

  modport master (output addr, output rq, input data, input rdy);
  modport slave  (input addr, input rq, output data, output rdy);
endinterface

// File: rtl/header_feeder_byte_loader.sv
// hdr_byte_loader: byte-wide rq/rdy handshake with the host plus byte counter.
// Emits a write strobe with the byte index at each capture and flags done
// once all header bytes are in and the request line has dropped.
module hdr_byte_loader
  import hdr_feeder_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       en,
  output logic       byte_rq,
  input  logic       byte_rdy,
  input  logic [7:0] byte_data,
  output logic       wr_en,
  output logic [6:0] wr_idx,
  output logic [7:0] wr_data,
  output logic       done
);

  logic [6:0] count;

  // Raise a request when idle and bytes remain; drop it on capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count   <= '0;
      byte_rq <= 1'b0;
    end else if (start) begin
      count   <= '0;
      byte_rq <= 1'b0;
    end else if (en) begin
      if (byte_rq && byte_rdy) begin
        byte_rq <= 1'b0;
        count   <= count + 7'd1;
      end else if (!byte_rq && (count < 7'(HDR_BYTES))) begin
        byte_rq <= 1'b1;
      end
    end
  end

  assign wr_en   = en && byte_rq && byte_rdy;
  assign wr_idx  = count;
  assign wr_data = byte_data;
  assign done    = en && !byte_rq && (count == 7'(HDR_BYTES));

endmodule

// File: rtl/header_feeder.sv
// header_feeder: stores an 80-byte block header loaded over the byte pins and
// serves 32-bit words to sha256d_wrapper. Owns the little-endian nonce field
// (word NONCE_WORD) so successive hash attempts need no pin traffic.
// Optional build macro HDR_FEEDER_AUTO_NONCE_EN adds a hash_done input that
// advances the nonce like nonce_inc (both together advance by one).
module header_feeder #(
  parameter int HDR_WORDS  = hdr_feeder_pkg::HDR_WORDS,
  parameter int NONCE_WORD = hdr_feeder_pkg::NONCE_WORD,
  parameter int ADDR_W     = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_start,
  output logic        byte_rq,
  input  logic        byte_rdy,
  input  logic [7:0]  byte_data,
  header_feeder_if.slave hs,
  input  logic        nonce_inc,
`ifdef HDR_FEEDER_AUTO_NONCE_EN
  input  logic        hash_done,
`endif
  output logic        hdr_valid,
  output logic [31:0] nonce,
  output logic        nonce_wrap
);
  import hdr_feeder_pkg::*;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  state_t      state;
  logic [31:0] words [HDR_WORDS];
  logic        rq_p0;
  logic        rq_edge;
  logic [31:0] rd_word;
  logic        advance;
  logic [31:0] nonce_nxt;

  logic        ld_start;
  logic        ld_wr;
  logic [6:0]  ld_idx;
  logic [7:0]  ld_data;
  logic        ld_done;

  assign ld_start = load_start && (state != ST_LOAD);

  hdr_byte_loader u_loader (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (ld_start),
    .en        (state == ST_LOAD),
    .byte_rq   (byte_rq),
    .byte_rdy  (byte_rdy),
    .byte_data (byte_data),
    .wr_en     (ld_wr),
    .wr_idx    (ld_idx),
    .wr_data   (ld_data),
    .done      (ld_done)
  );

`ifdef HDR_FEEDER_AUTO_NONCE_EN
  assign advance = nonce_inc | hash_done;
`else
  assign advance = nonce_inc;
`endif

  assign nonce     = bswap32(words[NONCE_WORD]);
  assign nonce_nxt = nonce + 32'd1;
  assign rq_edge   = hs.rq && !rq_p0;

  // Word lookup; addresses past the header read as zero.
  always_comb begin
    rd_word = '0;
    if (hs.addr < ADDR_W'(HDR_WORDS)) rd_word = words[hs.addr];
  end

  // Control FSM, header store, nonce update and word server.
  // The server samples the store before this edge's writes, so a request
  // coinciding with a nonce advance returns the pre-increment word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      hdr_valid  <= 1'b0;
      nonce_wrap <= 1'b0;
      hs.data    <= '0;
      hs.rdy     <= 1'b0;
      rq_p0      <= 1'b0;
      for (int i = 0; i < HDR_WORDS; i++) words[i] <= '0;
    end else begin
      rq_p0  <= hs.rq;
      hs.rdy <= rq_edge;
      if (rq_edge) hs.data <= rd_word;

      case (state)
        ST_IDLE: begin
          if (load_start) begin
            state      <= ST_LOAD;
            hdr_valid  <= 1'b0;
            nonce_wrap <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (ld_wr) words[byte_word(ld_idx)][byte_lane_lsb(ld_idx) +: 8] <= ld_data;
          if (ld_done) begin
            state     <= ST_READY;
            hdr_valid <= 1'b1;
          end
        end
        ST_READY: begin
          if (load_start) begin
            state      <= ST_LOAD;
            hdr_valid  <= 1'b0;
            nonce_wrap <= 1'b0;
          end else if (advance) begin
            words[NONCE_WORD] <= bswap32(nonce_nxt);
            if (nonce == 32'hFFFF_FFFF) nonce_wrap <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_header_feeder.sv
// Self-checking bench for header_feeder: a byte-array header model updated on
// each clock edge from the bench's own stimulus, compared every cycle, plus
// literal expectations from hand calculation.
module tb_header_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic        byte_rq;
  logic        byte_rdy = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        nonce_inc = 1'b0;
  logic        hdr_valid;
  logic [31:0] nonce;
  logic        nonce_wrap;
`ifdef HDR_FEEDER_AUTO_NONCE_EN
  logic        hash_done = 1'b0;
`endif

  header_feeder_if #(.ADDR_W(5)) bus ();

  header_feeder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .byte_rq    (byte_rq),
    .byte_rdy   (byte_rdy),
    .byte_data  (byte_data),
    .hs         (bus),
    .nonce_inc  (nonce_inc),
`ifdef HDR_FEEDER_AUTO_NONCE_EN
    .hash_done  (hash_done),
`endif
    .hdr_valid  (hdr_valid),
    .nonce      (nonce),
    .nonce_wrap (nonce_wrap)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  mhdr [80];
  bit          m_loading = 0;
  bit          m_fin = 0;
  int          m_cnt = 0;
  bit          m_valid = 0;
  bit          m_wrap = 0;
  bit          m_rdy = 0;
  logic [31:0] m_data = '0;
  bit          m_prev_rq = 0;

  function automatic logic [31:0] mword(input logic [4:0] a);
    int i;
    i = int'(a);
    if (i >= 20) return 32'h0;
    return {mhdr[4*i], mhdr[4*i+1], mhdr[4*i+2], mhdr[4*i+3]};
  endfunction

  function automatic logic [31:0] mnonce();
    return {mhdr[79], mhdr[78], mhdr[77], mhdr[76]};
  endfunction

  initial begin
    logic [31:0] n;
    bit adv;
    for (int i = 0; i < 80; i++) mhdr[i] = 8'h00;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        for (int i = 0; i < 80; i++) mhdr[i] = 8'h00;
        m_loading = 0; m_fin = 0; m_cnt = 0; m_valid = 0; m_wrap = 0;
        m_rdy = 0; m_data = '0; m_prev_rq = 0;
      end else begin
        if (bus.rq && !m_prev_rq) begin
          m_rdy = 1;
          m_data = mword(bus.addr);
        end else begin
          m_rdy = 0;
        end
        m_prev_rq = bus.rq;
        adv = nonce_inc;
`ifdef HDR_FEEDER_AUTO_NONCE_EN
        adv = adv | hash_done;
`endif
        if (m_loading) begin
          if (m_fin) begin
            m_loading = 0; m_fin = 0; m_valid = 1;
          end else if (byte_rdy) begin
            mhdr[m_cnt] = byte_data;
            m_cnt++;
            if (m_cnt == 80) m_fin = 1;
          end
        end else if (load_start) begin
          m_loading = 1; m_cnt = 0; m_valid = 0; m_wrap = 0;
        end else if (m_valid && adv) begin
          n = mnonce();
          if (n == 32'hFFFF_FFFF) m_wrap = 1;
          n = n + 32'd1;
          mhdr[76] = n[7:0];
          mhdr[77] = n[15:8];
          mhdr[78] = n[23:16];
          mhdr[79] = n[31:24];
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("hs_rdy", {31'b0, bus.rdy}, {31'b0, m_rdy});
        chk("hs_data", bus.data, m_data);
        chk("hdr_valid", {31'b0, hdr_valid}, {31'b0, m_valid});
        chk("nonce", nonce, mnonce());
        chk("nonce_wrap", {31'b0, nonce_wrap}, {31'b0, m_wrap});
        if (!m_loading) chk("byte_rq_idle", {31'b0, byte_rq}, 32'h0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] hdr_buf [80];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_inc();
    nonce_inc = 1'b1;
    tick();
    nonce_inc = 1'b0;
  endtask

  // Load the first nbytes of hdr_buf; host answers 1 cycle after byte_rq.
  // A nonce_inc pulse is injected while loading when inc_at >= 0.
  task automatic load_hdr(input int nbytes, input int inc_at);
    int cnt;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("load_clr_valid", {31'b0, hdr_valid}, 32'h0);
    chk("load_clr_wrap", {31'b0, nonce_wrap}, 32'h0);
    for (int i = 0; i < nbytes; i++) begin
      if (i == inc_at) pulse_inc();
      cnt = 0;
      while (!byte_rq && cnt < 20) begin
        tick();
        cnt++;
      end
      if (!byte_rq) begin
        chk("byte_rq_timeout", 32'h0, 32'h1);
        return;
      end
      byte_data = hdr_buf[i];
      byte_rdy = 1'b1;
      tick();
      byte_rdy = 1'b0;
    end
    if (nbytes == 80) begin
      tick();
      chk("load_done_valid", {31'b0, hdr_valid}, 32'h1);
    end
  endtask

  task automatic req(input logic [4:0] a, output logic [31:0] d);
    bus.addr = a;
    bus.rq = 1'b1;
    tick();
    d = bus.data;
    chk("req_rdy", {31'b0, bus.rdy}, 32'h1);
    bus.rq = 1'b0;
    tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] d;
    int pulses;
    bus.addr = '0;
    bus.rq = 1'b0;

    // Reset
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;
    chk("rst_byte_rq", {31'b0, byte_rq}, 32'h0);
    chk("rst_nonce", nonce, 32'h0);
    tick();

    // Pattern 1: bytes 0x00..0x4F, nonce_inc during LOAD ignored
    for (int i = 0; i < 80; i++) hdr_buf[i] = 8'(i);
    load_hdr(80, 5);
    req(5'd0, d);
    chk("lit_word0", d, 32'h00010203);
    req(5'd19, d);
    chk("lit_word19", d, 32'h4C4D4E4F);
    chk("lit_nonce", nonce, 32'h4F4E4D4C);

    // Out-of-range address and held request
    req(5'd25, d);
    chk("lit_addr25", d, 32'h0);
    bus.addr = 5'd3;
    bus.rq = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.rdy) pulses++;
    end
    bus.rq = 1'b0;
    tick();
    chk("lit_hold_pulses", 32'(pulses), 32'd1);
    chk("lit_hold_data", bus.data, 32'h0C0D0E0F);

    // Pattern 2: nonce FF FF FF FF wraps
    for (int i = 0; i < 80; i++) hdr_buf[i] = 8'(i * 3 + 7);
    for (int i = 76; i < 80; i++) hdr_buf[i] = 8'hFF;
    load_hdr(80, -1);
    chk("lit_nonce_max", nonce, 32'hFFFF_FFFF);
    pulse_inc();
    chk("lit_wrap_nonce", nonce, 32'h0);
    chk("lit_wrap_flag", {31'b0, nonce_wrap}, 32'h1);
    req(5'd19, d);
    chk("lit_wrap_word19", d, 32'h0);
    req(5'd1, d);
    chk("lit_p2_word1", d, 32'h131619_1C);

    // Pattern 3: nonce 5, simultaneous request and increment
    for (int i = 0; i < 80; i++) hdr_buf[i] = 8'($urandom_range(0, 255));
    hdr_buf[76] = 8'h05; hdr_buf[77] = 8'h00; hdr_buf[78] = 8'h00; hdr_buf[79] = 8'h00;
    load_hdr(80, -1);
    bus.addr = 5'd19;
    bus.rq = 1'b1;
    nonce_inc = 1'b1;
    tick();
    nonce_inc = 1'b0;
    chk("lit_sim_served", bus.data, 32'h05000000);
    chk("lit_sim_nonce", nonce, 32'h6);
    bus.rq = 1'b0;
    tick();
    req(5'd19, d);
    chk("lit_sim_next", d, 32'h06000000);

    // Reset after 30 bytes aborts the load
    for (int i = 0; i < 80; i++) hdr_buf[i] = 8'(i);
    load_hdr(30, -1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("lit_abort_rq", {31'b0, byte_rq}, 32'h0);
    chk("lit_abort_valid", {31'b0, hdr_valid}, 32'h0);
    for (int a = 0; a < 20; a++) begin
      req(5'(a), d);
      chk("lit_abort_word", d, 32'h0);
    end
    load_hdr(80, -1);
    req(5'd7, d);
    chk("lit_reload_word7", d, 32'h1C1D1E1F);

`ifdef HDR_FEEDER_AUTO_NONCE_EN
    // hash_done and nonce_inc together advance by one
    hdr_buf[76] = 8'h07; hdr_buf[77] = 8'h00; hdr_buf[78] = 8'h00; hdr_buf[79] = 8'h00;
    load_hdr(80, -1);
    hash_done = 1'b1;
    nonce_inc = 1'b1;
    tick();
    hash_done = 1'b0;
    nonce_inc = 1'b0;
    chk("lit_auto_both", nonce, 32'h8);
    hash_done = 1'b1;
    tick();
    hash_done = 1'b0;
    chk("lit_auto_done", nonce, 32'h9);
`endif

    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/header_feeder.md
# header_feeder

Block header store and word server sitting directly upstream of `sha256d_wrapper` in `tt_um_bitcoin`. Loads an 80-byte block header over the byte-wide `rq`/`rdy` pin handshake once, then answers the wrapper's 32-bit word requests (`addr`/`rq` → `data`/`rdy`) from local registers. Owns the nonce field so successive hash attempts need no pin traffic.

## Interface
- `HDR_WORDS`, 20, header length in 32-bit words (80 bytes)
- `NONCE_WORD`, 19, word index holding the nonce (header bytes 76..79)
- `ADDR_W`, 5, width of wrapper word address
- `clk`  in  1  clock
- `rst_n`  in  1  reset; synchronous, active-low
- `load_start`  in  1  begin a header load (level sampled)
- `byte_rq`  out  1  requests next header byte from host
- `byte_rdy`  in  1  host byte valid on `byte_data`
- `byte_data`  in  8  header byte, header order (byte 0 first)
- `hs_addr`  in  ADDR_W  word address from wrapper
- `hs_rq`  in  1  wrapper word request (level; rising edge = new request)
- `hs_data`  out  32  requested word
- `hs_rdy`  out  1  one-cycle pulse: `hs_data` valid
- `nonce_inc`  in  1  one-cycle pulse: advance nonce
- `hdr_valid`  out  1  full header loaded
- `nonce`  out  32  current nonce, numeric value
- `nonce_wrap`  out  1  sticky: nonce wrapped past 0xFFFFFFFF

## Operation
- States: IDLE, LOAD, READY.
- IDLE/READY + `load_start`=1 → LOAD; byte count ← 0, `hdr_valid` ← 0, `nonce_wrap` ← 0. `load_start` ignored in LOAD.
- LOAD byte handshake: `!byte_rq` and count<80 → raise `byte_rq`; `byte_rq && byte_rdy` → drop `byte_rq`, store byte, count++. Count==80 with `byte_rq` low → READY, `hdr_valid` ← 1.
- Byte n lands in word n/4, bits [31-8*(n%4) -: 8] (big-endian within word, matches wrapper).
- Nonce is little-endian in the header: `nonce` = {b79,b78,b77,b76}. Increment is done on that numeric value and written back in byte order.
- `nonce_inc` honoured only in READY; ignored in IDLE/LOAD. 0xFFFFFFFF+1 → 0x00000000, `nonce_wrap` ← 1.
- Word requests served in every state from current register contents (wrapper must never stall). `hs_addr` ≥ HDR_WORDS returns 0x00000000.
- `hs_rq` held high does not re-trigger; a new request needs `hs_rq` low for ≥1 cycle.

## Timing
- Reset (sync, `rst_n` low at edge): state IDLE, all header words 0, `byte_rq`=0, `hs_rdy`=0, `hs_data`=0, `hdr_valid`=0, `nonce_wrap`=0 (`nonce`=0). Reset mid-LOAD aborts, partial header discarded.
- Word serve: cycle k = first cycle `hs_rq`=1 after a 0 sample; at edge ending k, `hs_data` ← word[`hs_addr`], `hs_rdy` ← 1; `hs_rdy` high in cycle k+1 only. `hs_data` holds until the next request.
- Byte load: min 2 cycles per byte (rq rise, capture); 80 bytes ≥160 cycles; `hdr_valid` rises the cycle after the 80th capture edge + 1.
- `nonce_inc` at edge k: updated `nonce`/word 19 visible cycle k+1.
- Simultaneous request edge and `nonce_inc` in same cycle: served word 19 is the pre-increment value.

## Configuration
- `HDR_FEEDER_AUTO_NONCE_EN` defined: extra input `hash_done` (1 bit); `hash_done` pulse in READY advances nonce exactly as `nonce_inc`; both in same cycle advance by 1, not 2.
- Undefined: no `hash_done` port; nonce advances only on `nonce_inc`.

## Structure
- Shared package `hdr_feeder_pkg`: `HDR_BYTES`=80, `HDR_WORDS`=20, `NONCE_WORD`=19, state typedef (IDLE/LOAD/READY), byte→word/lane index helpers.
- One sub-module natural: `hdr_byte_loader` (byte rq/rdy handshake + 7-bit counter, emits byte/index strobe and done). Word store, nonce logic and request server stay in `header_feeder`.

## Test plan
- Load bytes 0x00..0x4F with `byte_rdy` 1 cycle after each `byte_rq` → `hdr_valid`=1; `hs_addr`=0 returns 0x00010203, `hs_addr`=19 returns 0x4C4D4E4F, `nonce`=0x4F4E4D4C.
- Nonce bytes FF FF FF FF, one `nonce_inc` → `nonce`=0, word 19=0x00000000, `nonce_wrap`=1; next `load_start` clears it.
- `hs_rq` rising with `hs_addr`=25 → `hs_rdy` pulse 1 cycle later, `hs_data`=0; `hs_rq` held 10 cycles → exactly one `hs_rdy`.
- `nonce_inc` and `hs_rq` edge for addr 19 same cycle, nonce 0x00000005 → served 0x05000000, subsequent request 0x06000000.
- `rst_n` low after 30 bytes loaded → IDLE, `byte_rq`=0, `hdr_valid`=0, all words read 0; fresh load completes normally.
- With `HDR_FEEDER_AUTO_NONCE_EN`: `hash_done` and `nonce_inc` same cycle from nonce 7 → nonce 8; `nonce_inc` during LOAD → no change.
